// File: rtl/ad_ip_jesd204_tpl_dac_fifo_if.sv
// DMA-side stream bundle feeding the TPL DAC FIFO.
// Master drives beats toward the FIFO. Slave is the FIFO side.
interface ad_ip_jesd204_tpl_dac_fifo_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  s_axis_valid;
  logic                  s_axis_ready;
  logic [DATA_WIDTH-1:0] s_axis_data;

  modport master (output s_axis_valid, output s_axis_data, input  s_axis_ready);
  modport slave  (input  s_axis_valid, input  s_axis_data, output s_axis_ready);
endinterface

// File: rtl/ad_ip_jesd204_tpl_dac_fifo_mem.sv
// Simple dual-port beat storage: one write port and one read port with a registered output.
module ad_ip_jesd204_tpl_dac_fifo_mem #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // registered read port; the output holds between reads
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_fifo.sv
// Prefill FIFO between the DAC DMA stream and the JESD204 TPL DAC sample interface.
// It fills to START_LEVEL first. It then pops one beat per dac_valid and flags underflow when empty.
module ad_ip_jesd204_tpl_dac_fifo #(
  parameter int DATA_WIDTH  = 128,
  parameter int DEPTH_LOG2  = 4,
  parameter int START_LEVEL = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  s_axis_valid,
  output logic                  s_axis_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_data,
  input  logic                  dac_valid,
  output logic [DATA_WIDTH-1:0] dac_ddata,
  output logic                  dac_dunf,
  output logic [DEPTH_LOG2:0]   fill_level
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_FILL = 2'd1;
  localparam logic [1:0] STATE_RUN  = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            state_next_s;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [PTR_W-1:0]      fill_level_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  unf_s;
  logic                  data_sel_r;
  logic                  dunf_r;
  logic [DATA_WIDTH-1:0] mem_rd_data_s;

  // The extra pointer MSB tells full apart from empty when the low address bits match.
  assign full_s       = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                        (wr_ptr_r[PTR_W-2:0] == rd_ptr_r[PTR_W-2:0]);
  assign empty_s      = (wr_ptr_r == rd_ptr_r);
  assign fill_level_s = wr_ptr_r - rd_ptr_r;

  // ready comes only from registered state, so a pop never opens it in the same cycle
  assign s_axis_ready = (state_r != STATE_IDLE) && !full_s;

  assign push_s = enable && s_axis_valid && s_axis_ready;
  assign pop_s  = enable && (state_r == STATE_RUN) && dac_valid && !empty_s;
  assign unf_s  = enable && (state_r == STATE_RUN) && dac_valid && empty_s;

  // next-state decode
  always_comb begin
    state_next_s = state_r;
    if (!enable) begin
      state_next_s = STATE_IDLE;
    end else begin
      case (state_r)
        STATE_IDLE: state_next_s = STATE_FILL;
        STATE_FILL: begin
          if (fill_level_s >= PTR_W'(START_LEVEL)) begin
            state_next_s = STATE_RUN;
          end else begin
            state_next_s = STATE_FILL;
          end
        end
        STATE_RUN:  state_next_s = STATE_RUN;
        default:    state_next_s = STATE_IDLE;
      endcase
    end
  end

  // state, pointers and output qualifiers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= STATE_IDLE;
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      data_sel_r <= 1'b0;
      dunf_r     <= 1'b0;
    end else begin
      state_r <= state_next_s;
      dunf_r  <= unf_s;
      if (!enable || (state_r == STATE_IDLE)) begin
        wr_ptr_r   <= {PTR_W{1'b0}};
        rd_ptr_r   <= {PTR_W{1'b0}};
        data_sel_r <= 1'b0;
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        if (state_r != STATE_RUN) begin
          data_sel_r <= 1'b0;
        end else if (pop_s) begin
          data_sel_r <= 1'b1;
        end else if (unf_s) begin
          data_sel_r <= 1'b0;
        end
      end
    end
  end

  ad_ip_jesd204_tpl_dac_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) i_mem (
    .clk     (clk),
    .wr_en   (push_s),
    .wr_addr (wr_ptr_r[DEPTH_LOG2-1:0]),
    .wr_data (s_axis_data),
    .rd_en   (pop_s),
    .rd_addr (rd_ptr_r[DEPTH_LOG2-1:0]),
    .rd_data (mem_rd_data_s)
  );

  // The read register is not reset, so it is masked until a real pop has loaded it.
  assign dac_ddata  = data_sel_r ? mem_rd_data_s : {DATA_WIDTH{1'b0}};
  assign dac_dunf   = dunf_r;
  assign fill_level = fill_level_s;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_fifo.sv
// Directed bench for the TPL DAC FIFO: prefill, ordering, full, underflow, flush and async reset.
module tb_ad_ip_jesd204_tpl_dac_fifo;

  localparam int DW = 128;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enable;
  logic         dac_valid;
  logic [DW-1:0] dac_ddata;
  logic         dac_dunf;
  logic [4:0]   fill_level;
  int           tests = 0;
  int           fails = 0;
  int           pops;

  ad_ip_jesd204_tpl_dac_fifo_if #(.DATA_WIDTH(DW)) axis ();

  ad_ip_jesd204_tpl_dac_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH_LOG2  (4),
    .START_LEVEL (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .s_axis_valid (axis.s_axis_valid),
    .s_axis_ready (axis.s_axis_ready),
    .s_axis_data  (axis.s_axis_data),
    .dac_valid    (dac_valid),
    .dac_ddata    (dac_ddata),
    .dac_dunf     (dac_dunf),
    .fill_level   (fill_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    dac_valid = 1'b0;
    axis.s_axis_valid = 1'b0;
    axis.s_axis_data = '0;
    tick();
    tick();
    chk("rst_ready", DW'(axis.s_axis_ready), DW'(1'b0));
    chk("rst_ddata", dac_ddata, '0);
    chk("rst_dunf", DW'(dac_dunf), DW'(1'b0));
    chk("rst_fill", DW'(fill_level), DW'(5'd0));

    resetn = 1'b1;
    tick();
    chk("idle_ready", DW'(axis.s_axis_ready), DW'(1'b0));
    enable = 1'b1;
    tick();
    chk("fill_ready", DW'(axis.s_axis_ready), DW'(1'b1));

    // prefill with dac_valid held high; FILL must ignore it
    dac_valid = 1'b1;
    axis.s_axis_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      axis.s_axis_data = DW'(32'h100 + i);
      tick();
    end
    chk("fill7_level", DW'(fill_level), DW'(5'd7));
    chk("fill7_ddata", dac_ddata, '0);
    chk("fill7_dunf", DW'(dac_dunf), DW'(1'b0));
    axis.s_axis_data = DW'(32'h107);
    tick();
    axis.s_axis_valid = 1'b0;
    chk("fill8_ddata", dac_ddata, '0);
    tick();
    chk("to_run_ddata", dac_ddata, '0);
    chk("to_run_level", DW'(fill_level), DW'(5'd8));
    tick();
    chk("first_pop", dac_ddata, DW'(32'h100));
    chk("first_pop_level", DW'(fill_level), DW'(5'd7));
    dac_valid = 1'b0;
    tick();
    chk("hold_ddata", dac_ddata, DW'(32'h100));

    // drain the rest, then underflow for two cycles
    dac_valid = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("drain", dac_ddata, DW'(32'h100 + i));
    end
    tick();
    chk("unf1_ddata", dac_ddata, '0);
    chk("unf1_dunf", DW'(dac_dunf), DW'(1'b1));
    tick();
    chk("unf2_dunf", DW'(dac_dunf), DW'(1'b1));
    chk("unf2_level", DW'(fill_level), DW'(5'd0));
    dac_valid = 1'b0;
    tick();
    chk("unf_clear", DW'(dac_dunf), DW'(1'b0));

    // push into an empty FIFO while requesting: underflow, beat still stored
    axis.s_axis_valid = 1'b1;
    axis.s_axis_data = DW'(32'habc);
    dac_valid = 1'b1;
    tick();
    chk("nobypass_dunf", DW'(dac_dunf), DW'(1'b1));
    chk("nobypass_level", DW'(fill_level), DW'(5'd1));
    axis.s_axis_valid = 1'b0;
    tick();
    chk("nobypass_pop", dac_ddata, DW'(32'habc));
    chk("nobypass_dunf0", DW'(dac_dunf), DW'(1'b0));
    dac_valid = 1'b0;

    // fill to full, then pop once
    axis.s_axis_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      axis.s_axis_data = DW'(32'h200 + i);
      tick();
    end
    chk("full_level", DW'(fill_level), DW'(5'd16));
    chk("full_ready", DW'(axis.s_axis_ready), DW'(1'b0));
    axis.s_axis_data = DW'(32'hdead);
    dac_valid = 1'b1;
    #1;
    chk("full_ready_same", DW'(axis.s_axis_ready), DW'(1'b0));
    tick();
    chk("full_pop_data", dac_ddata, DW'(32'h200));
    chk("full_pop_level", DW'(fill_level), DW'(5'd15));
    chk("full_pop_ready", DW'(axis.s_axis_ready), DW'(1'b1));
    axis.s_axis_data = DW'(32'h300);
    tick();
    chk("pushpop_level", DW'(fill_level), DW'(5'd15));
    chk("pushpop_data", dac_ddata, DW'(32'h201));

    // flush with enable=0, then restart
    axis.s_axis_valid = 1'b0;
    dac_valid = 1'b0;
    enable = 1'b0;
    tick();
    chk("flush_level", DW'(fill_level), DW'(5'd0));
    chk("flush_ddata", dac_ddata, '0);
    chk("flush_ready", DW'(axis.s_axis_ready), DW'(1'b0));
    enable = 1'b1;
    tick();
    chk("reen_ready", DW'(axis.s_axis_ready), DW'(1'b1));
    chk("reen_level", DW'(fill_level), DW'(5'd0));
    axis.s_axis_valid = 1'b1;
    dac_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      axis.s_axis_data = DW'(32'h400 + i);
      tick();
    end
    chk("refill_ddata", dac_ddata, '0);
    axis.s_axis_valid = 1'b0;
    tick();
    tick();
    chk("refill_pop", dac_ddata, DW'(32'h400));
    chk("refill_level", DW'(fill_level), DW'(5'd7));

    // continuous push with a request every second cycle
    pops = 0;
    axis.s_axis_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      axis.s_axis_data = DW'(32'h600 + i);
      dac_valid = (i % 2 == 0);
      tick();
      if (i % 2 == 0) begin
        chk("alt_data", dac_ddata, DW'(32'h401 + pops));
        pops++;
      end
      chk("alt_level", DW'(fill_level), DW'(7 + i + 1 - pops));
      chk("alt_dunf", DW'(dac_dunf), DW'(1'b0));
    end

    // asynchronous reset mid-RUN
    axis.s_axis_valid = 1'b0;
    dac_valid = 1'b1;
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_ddata", dac_ddata, '0);
    chk("arst_level", DW'(fill_level), DW'(5'd0));
    chk("arst_ready", DW'(axis.s_axis_ready), DW'(1'b0));
    chk("arst_dunf", DW'(dac_dunf), DW'(1'b0));
    tick();
    resetn = 1'b1;
    tick();
    chk("fresh_ready", DW'(axis.s_axis_ready), DW'(1'b1));
    chk("fresh_level", DW'(fill_level), DW'(5'd0));
    tick();
    chk("fresh_ddata", dac_ddata, '0);
    chk("fresh_dunf", DW'(dac_dunf), DW'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
